// File: rtl/l1_dc_wb_buf.sv
// L1 dcache write-back victim buffer: a small FIFO of dirty lines drained to L2 one line at a time.
// Optional feature macro WB_FWD_EN: when defined, queued line data is forwarded to refill lookups on rd_data.
module l1_dc_wb_buf #(
  parameter int DEPTH  = 2,   // 2 or 4; pointer wrap relies on a power-of-two depth
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_push,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [LINE_W-1:0] wb_data,
  output logic              wb_full,
  output logic              wb_empty,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [LINE_W-1:0] rd_data,
  input  logic              l2_busy,
  input  logic              l2_rdy,
  input  logic              l2_complete,
  output logic              l2_wr_req,
  output logic [ADDR_W-1:0] l2_wr_addr,
  output logic [LINE_W-1:0] l2_wr_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(4'hF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [LINE_W-1:0] data_d [DEPTH];

  logic              push_acc;
  logic              pop;
  logic              match_any;
  logic [PTR_W-1:0]  idx;
`ifdef WB_FWD_EN
  logic [PTR_W-1:0]  hit_idx;
`endif

  assign wb_full  = (count_q == FULL_CNT);
  assign wb_empty = (count_q == '0);

  // Full is the pre-edge value, so a push in a pop cycle of a full buffer is still dropped.
  assign push_acc = wb_push & ~wb_full;
  assign pop      = (state_q == S_WAIT) & l2_complete;

  // NOTE: every variable of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin : fifo_next
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push_acc) begin
      addr_d[tail_q] = wb_addr & LINE_MASK;
      data_d[tail_q] = wb_data;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!wb_empty && !l2_busy) state_d = S_REQ;
      S_REQ:  if (l2_rdy)                state_d = S_WAIT;
      S_WAIT: if (l2_complete)           state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: the line storage is reset because the head entry drives l2_wr_addr/l2_wr_data directly.
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // The head entry is not overwritten while draining: a push only lands on the head slot when empty.
  always_comb begin : fsm_out
    l2_wr_req  = (state_q == S_REQ);
    l2_wr_addr = addr_q[head_q];
    l2_wr_data = data_q[head_q];
  end

  // Walk entries oldest to youngest so the last match (nearest tail) wins.
  always_comb begin : lookup
    match_any = 1'b0;
    idx       = '0;
`ifdef WB_FWD_EN
    hit_idx   = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[idx] == (rd_addr & LINE_MASK))) begin
        match_any = 1'b1;
`ifdef WB_FWD_EN
        hit_idx   = idx;
`endif
      end
    end
  end

  assign rd_hit = rd_req & match_any;

`ifdef WB_FWD_EN
  assign rd_data = rd_hit ? data_q[hit_idx] : '0;
`else
  assign rd_data = '0;
`endif

endmodule

// File: tb/tb_l1_dc_wb_buf.sv
// Self-checking bench for l1_dc_wb_buf: directed test-plan scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the buffer and its L2 drain handshake.
module tb_l1_dc_wb_buf;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic              clk;
  logic              rst;
  logic              wb_push;
  logic [ADDR_W-1:0] wb_addr;
  logic [LINE_W-1:0] wb_data;
  logic              wb_full;
  logic              wb_empty;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [LINE_W-1:0] rd_data;
  logic              l2_busy;
  logic              l2_rdy;
  logic              l2_complete;
  logic              l2_wr_req;
  logic [ADDR_W-1:0] l2_wr_addr;
  logic [LINE_W-1:0] l2_wr_data;

  l1_dc_wb_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .wb_push     (wb_push),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_full     (wb_full),
    .wb_empty    (wb_empty),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_hit      (rd_hit),
    .rd_data     (rd_data),
    .l2_busy     (l2_busy),
    .l2_rdy      (l2_rdy),
    .l2_complete (l2_complete),
    .l2_wr_req   (l2_wr_req),
    .l2_wr_addr  (l2_wr_addr),
    .l2_wr_data  (l2_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } line_t;

  typedef enum {M_IDLE, M_REQ, M_WAIT} mphase_e;

  line_t   q[$];
  mphase_e ph = M_IDLE;
  int      errors = 0;
  int      checks = 0;
  int      overflow_seen = 0;
  int      overflow_exp = 0;

  // Push-while-full is an upstream protocol violation; count each one seen at a clock edge.
  always @(posedge clk) begin
    if (rst && wb_push && wb_full) overflow_seen++;
  end

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return (a >> 4) == (b >> 4);
  endfunction

  task automatic check_outputs();
    logic              exp_hit;
    logic [LINE_W-1:0] exp_data;
    exp_hit  = 1'b0;
    exp_data = '0;
    if (rd_req) begin
      foreach (q[i]) begin
        if (same_line(q[i].addr, rd_addr)) begin
          exp_hit  = 1'b1;
          exp_data = q[i].data;
        end
      end
    end
`ifndef WB_FWD_EN
    exp_data = '0;
`endif
    check("wb_full",   wb_full,   q.size() == DEPTH);
    check("wb_empty",  wb_empty,  q.size() == 0);
    check("l2_wr_req", l2_wr_req, ph == M_REQ);
    check("rd_hit",    rd_hit,    exp_hit);
    check("rd_data",   rd_data,   exp_data);
    if (q.size() != 0) begin
      check("l2_wr_addr", l2_wr_addr, q[0].addr);
      check("l2_wr_data", l2_wr_data, q[0].data);
    end
  endtask

  // Advance the model across one rising edge using the inputs applied during this cycle.
  task automatic model_step();
    bit push_ok;
    bit do_pop;
    push_ok = wb_push && (q.size() < DEPTH);
    do_pop  = (ph == M_WAIT) && l2_complete;
    if (wb_push && !push_ok) overflow_exp++;
    case (ph)
      M_IDLE: if (q.size() != 0 && !l2_busy) ph = M_REQ;
      M_REQ:  if (l2_rdy) ph = M_WAIT;
      M_WAIT: if (l2_complete) ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
    if (do_pop) void'(q.pop_front());
    if (push_ok) q.push_back('{addr: wb_addr & ~ADDR_W'(4'hF), data: wb_data});
  endtask

  task automatic cycle();
    #2;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb_push     = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    l2_busy     = 1'b0;
    l2_rdy      = 1'b0;
    l2_complete = 1'b0;
  endtask

  // L2 responder: accept whenever the DUT requests, complete as soon as the write is in flight.
  task automatic drain_all(input int budget);
    int n;
    n = 0;
    wb_push = 1'b0;
    l2_busy = 1'b0;
    while ((q.size() != 0 || ph != M_IDLE) && n < budget) begin
      l2_rdy      = l2_wr_req;
      l2_complete = (ph == M_WAIT);
      cycle();
      n++;
    end
    l2_rdy      = 1'b0;
    l2_complete = 1'b0;
    check("drain_timeout", n >= budget, 1'b0);
  endtask

  task automatic advance_to_wait(input int budget);
    int n;
    n = 0;
    l2_busy = 1'b0;
    while (ph != M_WAIT && n < budget) begin
      l2_rdy = l2_wr_req;
      cycle();
      n++;
    end
    l2_rdy = 1'b0;
    check("wait_timeout", n >= budget, 1'b0);
  endtask

  task automatic push_line(input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    wb_push = 1'b1;
    wb_addr = a;
    wb_data = d;
    cycle();
    wb_push = 1'b0;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [LINE_W-1:0] a5;
    logic [LINE_W-1:0] d1;
    logic [LINE_W-1:0] d2;
    a5 = {16{8'hA5}};
    d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123;

    // Reset state
    clear_inputs();
    rst = 1'b0;
    #3;
    check_outputs();
    check("rst_l2_wr_addr", l2_wr_addr, '0);
    check("rst_l2_wr_data", l2_wr_data, '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single drain: request two cycles after the push
    push_line(32'h0000_1230, a5);
    cycle();
    #1;
    check("sd_req",  l2_wr_req,  1'b1);
    check("sd_addr", l2_wr_addr, 32'h0000_1230);
    check("sd_data", l2_wr_data, a5);
    l2_rdy = 1'b1;
    cycle();
    l2_rdy      = 1'b0;
    l2_complete = 1'b1;
    cycle();
    l2_complete = 1'b0;
    #1;
    check("sd_empty", wb_empty, 1'b1);
    cycle();

    // Fill to full while L2 is busy; the third push is dropped
    l2_busy = 1'b1;
    push_line(32'h0000_0100, d1);
    push_line(32'h0000_0200, d2);
    #1;
    check("ff_full", wb_full, 1'b1);
    push_line(32'h0000_0300, a5);
    #1;
    check("ff_still_full", wb_full, 1'b1);
    check("ff_head_addr", l2_wr_addr, 32'h0000_0100);
    drain_all(40);

    // Full buffer: push in the complete cycle is rejected
    l2_busy = 1'b1;
    push_line(32'h0000_0400, d1);
    push_line(32'h0000_0500, d2);
    advance_to_wait(20);
    wb_push     = 1'b1;
    wb_addr     = 32'h0000_0600;
    wb_data     = a5;
    l2_complete = 1'b1;
    cycle();
    wb_push     = 1'b0;
    l2_complete = 1'b0;
    #1;
    check("sp_full_rej_addr", l2_wr_addr, 32'h0000_0500);
    check("sp_full_rej_full", wb_full, 1'b0);
    // One entry: push in the complete cycle keeps count at one and drains next
    advance_to_wait(20);
    wb_push     = 1'b1;
    wb_addr     = 32'h0000_0700;
    wb_data     = d1;
    l2_complete = 1'b1;
    cycle();
    wb_push     = 1'b0;
    l2_complete = 1'b0;
    #1;
    check("sp_one_empty", wb_empty, 1'b0);
    check("sp_one_full",  wb_full,  1'b0);
    check("sp_one_head",  l2_wr_addr, 32'h0000_0700);
    drain_all(40);

    // Lookup with duplicate lines: the youngest wins
    l2_busy = 1'b1;
    push_line(32'h0000_0300, d1);
    push_line(32'h0000_0300, d2);
    rd_req  = 1'b1;
    rd_addr = 32'h0000_030C;
    #1;
    check("lk_hit", rd_hit, 1'b1);
`ifdef WB_FWD_EN
    check("lk_data", rd_data, d2);
`else
    check("lk_data", rd_data, '0);
`endif
    drain_all(40);
    #1;
    check("lk_hit_after", rd_hit, 1'b0);
    rd_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      wb_push     = ($urandom_range(0, 2) == 0) && (q.size() < DEPTH);
      wb_addr     = {$urandom_range(1, 4), 8'h00} | ADDR_W'($urandom_range(0, 15));
      wb_data     = rand_line();
      rd_req      = $urandom_range(0, 1);
      rd_addr     = {$urandom_range(1, 5), 8'h00} | ADDR_W'($urandom_range(0, 15));
      l2_busy     = ($urandom_range(0, 3) == 0);
      l2_rdy      = $urandom_range(0, 1);
      l2_complete = $urandom_range(0, 1);
      cycle();
    end
    clear_inputs();
    drain_all(40);

    // Reset in the middle of a WAIT clears everything without a clock edge
    l2_busy = 1'b1;
    push_line(32'h0000_0800, d1);
    advance_to_wait(20);
    #2;
    rst = 1'b0;
    #1;
    check("mr_req",   l2_wr_req, 1'b0);
    check("mr_empty", wb_empty,  1'b1);
    check("mr_addr",  l2_wr_addr, '0);
    q.delete();
    ph = M_IDLE;
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push_line(32'h0000_0900, d2);
    cycle();
    #1;
    check("mr_after_req",  l2_wr_req,  1'b1);
    check("mr_after_addr", l2_wr_addr, 32'h0000_0900);
    drain_all(40);

    check("overflow_count", overflow_seen, overflow_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
